// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the sequential multiply/divide unit
//
// Purpose : FSM state encoding, datapath widths, iteration counts and the
//           radix-4 Booth recoding used by seq_multdiv and multdiv_counter.
// Ports   : none (package).
// Config  : the divider datapath is included only when MULTDIV_DIV_EN is defined.

package multdiv_pkg;

    localparam int DATA_W     = 32;
    localparam int MULT_ITERS = 16;
    localparam int DIV_ITERS  = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Radix-4 Booth digit selected by multiplier bits {b(2i+1), b(2i), b(2i-1)}
    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'd0,
        BOOTH_ADD1 = 3'd1,
        BOOTH_ADD2 = 3'd2,
        BOOTH_SUB1 = 3'd3,
        BOOTH_SUB2 = 3'd4
    } booth_op_e;

    function automatic booth_op_e booth_decode(input logic [2:0] bits);
        booth_op_e op;
        case (bits)
            3'b001, 3'b010: op = BOOTH_ADD1;
            3'b011:         op = BOOTH_ADD2;
            3'b100:         op = BOOTH_SUB2;
            3'b101, 3'b110: op = BOOTH_SUB1;
            default:        op = BOOTH_ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multdiv_counter.sv
// rtl/multdiv_counter.sv - 6-bit load/decrement iteration counter with zero flag
//
// Purpose : counts remaining iterations for the multiply/divide FSM.
// Ports   : clock, reset_n (async active-low)
//           load      - load load_val (has priority over dec)
//           load_val  - value to load
//           dec       - decrement by one; holds at zero
//           zero      - count equals zero

module multdiv_counter
    import multdiv_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_multdiv.sv
// rtl/seq_multdiv.sv - sequential signed 32-bit multiplier (radix-4 Booth) and divider (non-restoring)
//
// Purpose : one operation at a time; a start pulse latches the operands, the
//           result and exception flag are registered and presented with a
//           one-cycle data_resultRDY pulse.
// Ports   : clock, reset_n (async active-low)
//           ctrl_MULT, ctrl_DIV        - start pulses (MULT wins if both)
//           data_operandA/B            - two's complement operands
//           data_result                - product low word or quotient
//           data_exception             - overflow / divide-by-zero
//           data_resultRDY             - completion pulse
//           busy                       - operation in flight
// Config  : MULTDIV_DIV_EN defined includes the divider; otherwise a divide
//           request completes one cycle later with result 0 and exception 1.

module seq_multdiv
    import multdiv_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    output logic [DATA_W-1:0] data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              busy
);

    localparam int PROD_W = 2*DATA_W + 2;

    state_e              state;
    logic [PROD_W-1:0]   prod;
    logic [DATA_W-1:0]   mcand;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero;
    logic [CNT_W-1:0]    cnt_load_val;

    // Any start reloads the counter, which is also how an abort restarts.
    assign cnt_load     = ctrl_MULT | ctrl_DIV;
    assign cnt_load_val = ctrl_MULT ? CNT_W'(MULT_ITERS) : CNT_W'(DIV_ITERS);
    assign cnt_dec      = (state == ST_MULT) || (state == ST_DIV);

    multdiv_counter u_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Booth step: prod = {upper accumulator[65:33], multiplier[32:1], b(-1)[0]}.
    // The accumulator is widened by one bit for the add, then the whole
    // register shifts right arithmetically by two.
    booth_op_e                 booth_op;
    logic signed [DATA_W+1:0]  m_ext;
    logic signed [DATA_W+1:0]  booth_addend;
    logic signed [DATA_W+1:0]  booth_sum;
    logic [PROD_W-1:0]         prod_next;
    logic [2*DATA_W-1:0]       product;
    logic                      mult_ovf;

    always_comb begin
        booth_op     = booth_decode(prod[2:0]);
        m_ext        = {{2{mcand[DATA_W-1]}}, mcand};
        booth_addend = '0;
        case (booth_op)
            BOOTH_ADD1: booth_addend = m_ext;
            BOOTH_ADD2: booth_addend = m_ext <<< 1;
            BOOTH_SUB1: booth_addend = -m_ext;
            BOOTH_SUB2: booth_addend = -(m_ext <<< 1);
            default:    booth_addend = '0;
        endcase
        booth_sum = $signed({prod[PROD_W-1], prod[PROD_W-1:DATA_W+1]}) + booth_addend;
        prod_next = {booth_sum[DATA_W+1], booth_sum, prod[DATA_W:2]};
    end

    assign product  = prod[2*DATA_W:1];
    // Signed 32-bit overflow: bits [63:31] must all be copies of the sign.
    assign mult_ovf = !((&product[2*DATA_W-1:DATA_W-1]) || !(|product[2*DATA_W-1:DATA_W-1]));

`ifdef MULTDIV_DIV_EN
    // Non-restoring division on magnitudes. rem is signed and one bit wider
    // than a doubled divisor so the shifted partial remainder never wraps.
    logic signed [DATA_W+1:0] rem;
    logic signed [DATA_W+1:0] rem_sh;
    logic signed [DATA_W+1:0] rem_next;
    logic signed [DATA_W+1:0] dvsr_ext;
    logic [DATA_W-1:0]        quo;
    logic [DATA_W-1:0]        dvsr;
    logic [DATA_W-1:0]        mag_a;
    logic [DATA_W-1:0]        mag_b;
    logic                     q_neg;
    logic                     div_zero;
    logic                     div_ovf;
    logic                     fix_done;

    always_comb begin
        mag_a    = data_operandA[DATA_W-1] ? -data_operandA : data_operandA;
        mag_b    = data_operandB[DATA_W-1] ? -data_operandB : data_operandB;
        dvsr_ext = {2'b00, dvsr};
        rem_sh   = {rem[DATA_W:0], quo[DATA_W-1]};
        rem_next = rem[DATA_W+1] ? (rem_sh + dvsr_ext) : (rem_sh - dvsr_ext);
    end
`else
    logic div_pend;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            prod           <= '0;
            mcand          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
`ifdef MULTDIV_DIV_EN
            rem            <= '0;
            quo            <= '0;
            dvsr           <= '0;
            q_neg          <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            fix_done       <= 1'b0;
`else
            div_pend       <= 1'b0;
`endif
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_MULT) begin
                state <= ST_MULT;
                busy  <= 1'b1;
                mcand <= data_operandA;
                prod  <= {{(DATA_W+1){1'b0}}, data_operandB, 1'b0};
`ifndef MULTDIV_DIV_EN
                div_pend <= 1'b0;
`endif
            end else if (ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
                state    <= ST_DIV;
                busy     <= 1'b1;
                rem      <= '0;
                quo      <= mag_a;
                dvsr     <= mag_b;
                q_neg    <= data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
                div_zero <= (data_operandB == '0);
                div_ovf  <= 1'b0;
                fix_done <= 1'b0;
`else
                // Wait one cycle in IDLE so the error completes after the next edge.
                state    <= ST_IDLE;
                busy     <= 1'b0;
                div_pend <= 1'b1;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
`ifndef MULTDIV_DIV_EN
                        if (div_pend) begin
                            state          <= ST_DONE;
                            div_pend       <= 1'b0;
                            data_resultRDY <= 1'b1;
                            data_result    <= '0;
                            data_exception <= 1'b1;
                        end
`endif
                    end
                    ST_MULT: begin
                        if (cnt_zero) begin
                            state          <= ST_DONE;
                            busy           <= 1'b0;
                            data_resultRDY <= 1'b1;
                            data_result    <= product[DATA_W-1:0];
                            data_exception <= mult_ovf;
                        end else begin
                            prod <= prod_next;
                        end
                    end
                    ST_DIV: begin
`ifdef MULTDIV_DIV_EN
                        if (!cnt_zero) begin
                            rem <= rem_next;
                            quo <= {quo[DATA_W-2:0], ~rem_next[DATA_W+1]};
                        end else if (!fix_done) begin
                            // Apply sign; a positive 2^31 quotient cannot be represented.
                            quo      <= q_neg ? -quo : quo;
                            div_ovf  <= !q_neg && quo[DATA_W-1];
                            fix_done <= 1'b1;
                        end else begin
                            state          <= ST_DONE;
                            busy           <= 1'b0;
                            data_resultRDY <= 1'b1;
                            data_result    <= div_zero ? '0 : quo;
                            data_exception <= div_zero | div_ovf;
                        end
`else
                        state <= ST_IDLE;
                        busy  <= 1'b0;
`endif
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_multdiv.sv
// tb/tb_seq_multdiv.sv - scoreboard bench for seq_multdiv

module tb_seq_multdiv;

`ifdef MULTDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int MULT_LAT = 17;
    localparam int DIV_LAT  = DIV_EN ? 34 : 1;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    seq_multdiv dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          at;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_res = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: pulse at cycle %0d with nothing pending, result %h", cyc, data_result);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result",    data_result,           mon_e.res);
                chk("exception", {31'b0, data_exception}, {31'b0, mon_e.exc});
                chk("latency",   cyc,                   mon_e.at);
            end
        end
    end

    // Start pulse sampled by the next rising edge; e0 is that edge's index.
    // Operands are scrambled afterwards to prove they were latched.
    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b, output int e0);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        e0            = cyc;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic push(input logic [31:0] res, input bit exc, input int at);
        exp_t e;
        e.res = res;
        e.exc = exc;
        e.at  = at;
        sb_q.push_back(e);
        last_res = res;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_rdy: %0d completions still pending at cycle %0d", sb_q.size(), cyc);
            sb_q.delete();
        end
        chk("hold_result", data_result, last_res);
        chk("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    task automatic run(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input bit exc);
        int e0;
        bit is_div;
        is_div = !m;
        issue(m, d, a, b, e0);
        if (is_div) begin
            push(DIV_EN ? res : 32'h0, DIV_EN ? exc : 1'b1, e0 + DIV_LAT);
            chk("busy_div", {31'b0, busy}, {31'b0, DIV_EN});
        end else begin
            push(res, exc, e0 + MULT_LAT);
            chk("busy_mult", {31'b0, busy}, 32'd1);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int e1;

        #1;
        chk("rst_result", data_result, 32'h0);
        chk("rst_exc",    {31'b0, data_exception}, 32'd0);
        chk("rst_rdy",    {31'b0, data_resultRDY}, 32'd0);
        chk("rst_busy",   {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // First start lands on the first edge after release
        run(1, 0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run(1, 1, 32'hFFFF_FFFA, 32'd5,        32'hFFFF_FFE2, 1'b0);
        run(1, 0, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0);
        run(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        run(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);

        run(0, 1, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 1'b0);
        run(0, 1, 32'd5,        32'd0,         32'h0000_0000, 1'b1);
        run(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run(0, 1, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        run(0, 1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0);

        // Divide at E5 aborts a multiply in flight
        issue(1, 0, 32'd3, 32'd4, e0);
        repeat (4) @(posedge clock);
        #1;
        issue(0, 1, 32'd100, 32'd10, e1);
        push(DIV_EN ? 32'd10 : 32'd0, !DIV_EN, e1 + DIV_LAT);
        drain();

        // Start accepted in the DONE cycle; the earlier completion still pulses
        issue(1, 0, 32'd2, 32'd3, e0);
        push(32'd6, 1'b0, e0 + MULT_LAT);
        repeat (17) @(posedge clock);
        #1;
        issue(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e1);
        push(32'd1, 1'b0, e1 + MULT_LAT);
        drain();

        run(1, 0, 32'd12345, 32'hFFFF_FD5A, 32'hFF80_490A, 1'b0);

        // Reset in the middle of a multiply
        issue(1, 0, 32'h0000_1234, 32'h0000_0010, e0);
        repeat (10) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_result", data_result, 32'h0);
        chk("midrst_exc",    {31'b0, data_exception}, 32'd0);
        chk("midrst_rdy",    {31'b0, data_resultRDY}, 32'd0);
        chk("midrst_busy",   {31'b0, busy}, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        last_res = 32'h0;
        repeat (40) @(posedge clock);

        run(1, 0, 32'd3, 32'd4, 32'd12, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_multdiv.md
SEQ_MULTDIV -- requirements
Module: seq_multdiv

Interface
REQ-001 SHALL provide: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: ctrl_MULT  input  1  one-cycle start pulse for a signed multiply.
REQ-004 SHALL provide: ctrl_DIV  input  1  one-cycle start pulse for a signed divide.
REQ-005 SHALL provide: data_operandA  input  32  multiplicand or dividend, two's complement.
REQ-006 SHALL provide: data_operandB  input  32  multiplier or divisor, two's complement.
REQ-007 SHALL provide: data_result  output  32  product low word or quotient; registered.
REQ-008 SHALL provide: data_exception  output  1  overflow or divide-by-zero flag, valid with data_resultRDY.
REQ-009 SHALL provide: data_resultRDY  output  1  one-cycle completion pulse.
REQ-010 SHALL provide: busy  output  1  high while an operation is in flight.

Function
REQ-011 Operands SHALL be latched on the edge that samples a start pulse; later operand changes SHALL have no effect.
REQ-012 FSM states SHALL be IDLE, MULT, DIV and DONE; IDLE->MULT/DIV on start, MULT/DIV->DONE when the iteration count expires, DONE->IDLE otherwise.
REQ-013 Multiply SHALL use radix-4 modified Booth with a 66-bit product register, 16 iterations, one per cycle.
REQ-014 Multiply latency SHALL be fixed: start sampled at edge E0, data_resultRDY high for exactly the cycle following edge E17.
REQ-015 Multiply exception SHALL be 1 iff product bits [63:31] are not all equal (signed 32-bit overflow).
REQ-016 Divide SHALL use non-restoring division on operand magnitudes, 32 iterations, plus one sign-fix cycle; data_resultRDY follows edge E34.
REQ-017 Quotient SHALL truncate toward zero; the remainder is discarded.
REQ-018 Divisor 0 SHALL give data_result 0 and data_exception 1 at the normal divide latency.
REQ-019 0x80000000 / 0xFFFFFFFF SHALL give data_result 0x80000000 and data_exception 1.
REQ-020 data_result and data_exception SHALL update only on the edge asserting data_resultRDY and SHALL hold until the next completion.
REQ-021 A start while busy SHALL abort the current operation without a completion pulse and restart with the new operands.
REQ-022 A start in the DONE cycle SHALL be accepted; the DONE pulse still completes.
REQ-023 Simultaneous ctrl_MULT and ctrl_DIV SHALL start a multiply (MULT priority).
REQ-024 busy SHALL be high in MULT and DIV and low in IDLE and DONE.

Reset
REQ-025 reset_n low SHALL asynchronously force state IDLE, iteration counter 0, data_result 0x00000000, data_exception 0, data_resultRDY 0, busy 0.
REQ-026 reset_n asserted mid-operation SHALL discard it with no completion pulse after release.
REQ-027 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-028 Macro MULTDIV_DIV_EN defined SHALL include the divider datapath and DIV state.
REQ-029 Without MULTDIV_DIV_EN, ctrl_DIV SHALL go IDLE->DONE directly (pulse after edge E1) with data_result 0 and data_exception 1; multiply behaviour SHALL be unchanged.

Structure
REQ-030 Package multdiv_pkg SHALL hold the state enum, MULT_ITERS=16, DIV_ITERS=32, DATA_W=32 and Booth recode constants.
REQ-031 A single sub-module multdiv_counter (6-bit load/decrement counter with zero flag) SHALL provide iteration counting; all other logic stays in seq_multdiv.

Verification
REQ-032 MULT A=7, B=-3 -> after E17 data_result 0xFFFFFFEB, data_exception 0, one-cycle data_resultRDY.
REQ-033 MULT A=0x00010000, B=0x00010000 -> data_result 0x00000000, data_exception 1.
REQ-034 DIV A=-100, B=7 -> after E34 data_result 0xFFFFFFF2 (-14), data_exception 0; DIV A=5, B=0 -> result 0, exception 1.
REQ-035 MULT 3x4 started, ctrl_DIV 100/10 pulsed at E5 -> no pulse for the multiply; single pulse 34 cycles after E5 with data_result 10.
REQ-036 reset_n pulsed low at E10 of a multiply -> outputs zero immediately, no data_resultRDY within the following 40 cycles.
